// File: rtl/fetch_prefetch_unit_if.sv
// Bus between the fetch/prefetch stage and its surroundings.
// Groups the redirect inputs, decode control, instruction-memory read
// port and the decode-side outputs.
//   master : environment side (drives redirects, stalls, imem data)
//   slave  : fetch unit side (drives PCF and decode outputs)
interface fetch_prefetch_unit_if #(
  parameter int N     = 24,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  ResultW;
  logic [N-1:0]  ALUResultE;
  logic          PCSrcW;
  logic          BranchTakenE;
  logic          StallD;
  logic          FlushD;
  logic [N-1:0]  imem_rdata;
  logic          imem_ready;
  logic [N-1:0]  PCF;
  logic [N-1:0]  InstrD;
  logic [N-1:0]  InstrD_vector;
  logic          InstrValidD;
  logic [N-1:0]  PCPlus8D;
  logic [CW-1:0] QueueCount;

  modport master (
    output ResultW, ALUResultE, PCSrcW, BranchTakenE, StallD, FlushD,
           imem_rdata, imem_ready,
    input  PCF, InstrD, InstrD_vector, InstrValidD, PCPlus8D, QueueCount
  );

  modport slave (
    input  ResultW, ALUResultE, PCSrcW, BranchTakenE, StallD, FlushD,
           imem_rdata, imem_ready,
    output PCF, InstrD, InstrD_vector, InstrValidD, PCPlus8D, QueueCount
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch queue in front of the decode
// register. PCF walks ahead while decode is stalled; a writeback PC write
// (PCSrcW) or a taken execute branch (BranchTakenE) redirects fetch and
// discards everything fetched so far. The decode word is split into a
// scalar and a vector path by bit 20.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous reset, active low
//   bus  - fetch_prefetch_unit_if.slave: redirect/stall/flush inputs,
//          imem read port (PCF out, imem_rdata/imem_ready in), decode
//          outputs InstrD, InstrD_vector, InstrValidD, PCPlus8D, QueueCount
// N must be at least 21 so that the vector flag bit exists.
module fetch_prefetch_unit #(
  parameter int           N        = 24,
  parameter int           DEPTH    = 4,
  parameter int           PC_STEP  = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  fetch_prefetch_unit_if.slave bus
);
  localparam int              AW    = $clog2(DEPTH);
  localparam int              CW    = AW + 1;
  localparam int              V_BIT = 20;
  localparam logic [N-1:0]    STEP  = N'(PC_STEP);
  localparam logic [N-1:0]    STEP2 = N'(2 * PC_STEP);
  localparam logic [CW-1:0]   FULL  = CW'(DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  pcf_reg, pcf_next;
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  dec_instr_reg, dec_instr_next;
  logic [N-1:0]  dec_pc_reg, dec_pc_next;
  logic          dec_valid_reg, dec_valid_next;
  logic          push, pop;

  // Queue storage. The head must be visible in the same cycle it is popped,
  // so reads are combinational; DEPTH is small, so this maps to registers.
  logic [N-1:0]  pc_mem    [DEPTH];
  logic [N-1:0]  instr_mem [DEPTH];

  always_comb begin
    state_next     = state_reg;
    pcf_next       = pcf_reg;
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    dec_instr_next = dec_instr_reg;
    dec_pc_next    = dec_pc_reg;
    dec_valid_next = dec_valid_reg;
    push           = 1'b0;
    pop            = 1'b0;

    if (state_reg == BOOT) begin
      // One idle cycle after reset release: no fetch, no decode load.
      state_next = RUN;
    end else if (bus.PCSrcW || bus.BranchTakenE) begin
      // Writeback redirect wins over the execute branch.
      pcf_next       = bus.PCSrcW ? bus.ResultW : bus.ALUResultE;
      head_next      = '0;
      tail_next      = '0;
      count_next     = '0;
      dec_instr_next = '0;
      dec_pc_next    = '0;
      dec_valid_next = 1'b0;
    end else begin
      pop  = !bus.StallD && !bus.FlushD && (count_reg != '0);
      // A full queue still accepts a new word when the head leaves.
      push = bus.imem_ready && ((count_reg != FULL) || pop);

      if (pop) begin
        dec_instr_next = instr_mem[head_reg];
        dec_pc_next    = pc_mem[head_reg];
        dec_valid_next = 1'b1;
        head_next      = head_reg + AW'(1);
      end else if (bus.FlushD || !bus.StallD) begin
        // Flush overrides stall; an unstalled empty queue also yields a bubble.
        dec_instr_next = '0;
        dec_pc_next    = '0;
        dec_valid_next = 1'b0;
      end

      if (push) begin
        tail_next = tail_reg + AW'(1);
        pcf_next  = pcf_reg + STEP;
      end

      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= BOOT;
      pcf_reg       <= RESET_PC;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      dec_instr_reg <= '0;
      dec_pc_reg    <= '0;
      dec_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pcf_reg       <= pcf_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      dec_instr_reg <= dec_instr_next;
      dec_pc_reg    <= dec_pc_next;
      dec_valid_reg <= dec_valid_next;
    end
  end

  // Entry records the address it was fetched from, used later for PCPlus8D.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[tail_reg]    <= pcf_reg;
      instr_mem[tail_reg] <= bus.imem_rdata;
    end
  end

  assign bus.PCF           = pcf_reg;
  assign bus.QueueCount    = count_reg;
  assign bus.InstrValidD   = dec_valid_reg;
  assign bus.InstrD        = (dec_valid_reg && !dec_instr_reg[V_BIT]) ? dec_instr_reg : '0;
  assign bus.InstrD_vector = (dec_valid_reg &&  dec_instr_reg[V_BIT]) ? dec_instr_reg : '0;
  assign bus.PCPlus8D      = dec_valid_reg ? (dec_pc_reg + STEP2) : '0;
endmodule
